// File: rtl/l2t_arb_pkg.sv
// Shared widths and the message record used by the Logic->TX arbiter.
// The ARB_STATS_EN macro in l2t_arbiter enables the grant/stall statistics counters.
package l2t_arb_pkg;

    localparam int TYPE_W = 8;
    localparam int DATA_W = 32;
    localparam int TS_W   = 32;

    typedef struct packed {
        logic [TYPE_W-1:0] msg_type;
        logic [DATA_W-1:0] data;
    } l2t_msg_t;

endpackage

// File: rtl/l2t_arbiter_rr_grant.sv
// Combinational round-robin pick: rotate by ptr, take the lowest set bit, rotate back.
// ptr is always below N, so the unrotated index never needs a general modulo.
module rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           found;
    int             pos;

    always_comb begin
        dbl   = {req, req};
        rot   = N'(dbl >> ptr);
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = int'(ptr) + i;
                if (pos >= N) pos = pos - N;
            end
        end
        if (found) begin
            grant[pos] = 1'b1;
            idx        = IDX_W'(pos);
        end
    end

endmodule

// File: rtl/l2t_arbiter.sv
// Round-robin arbiter feeding one registered output slot into the Logic->TX stage.
// Define ARB_STATS_EN to enable per-requester grant and stall counters (otherwise tied to 0).
module l2t_arbiter
    import l2t_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int STAT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [TS_W-1:0]             cycle_cnt,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TYPE_W-1:0]   req_type,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [TYPE_W-1:0]           out_type,
    output logic [DATA_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    output logic [TS_W-1:0]             out_t_grant,
    input  logic                        out_ready,
    output logic [NUM_REQ*STAT_W-1:0]   stat_grants,
    output logic [STAT_W-1:0]           stat_stall
);

    // Handshake: a requester's message transfers on a posedge where req_valid[i] && req_ready[i];
    // the slot transfers downstream on a posedge where out_valid && out_ready. Both sides
    // hold valid and payload stable until accepted.
    l2t_msg_t             msgs [NUM_REQ];
    logic [SRC_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [SRC_W-1:0]     grant_idx;
    logic                 load_en;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign msgs[g].msg_type = req_type[g*TYPE_W +: TYPE_W];
        assign msgs[g].data     = req_data[g*DATA_W +: DATA_W];
    end

    rr_grant #(.N(NUM_REQ), .IDX_W(SRC_W)) u_rr_grant (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign load_en   = (!out_valid || out_ready) && (|req_valid);
    assign req_ready = grant & {NUM_REQ{load_en && !rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_type    <= '0;
            out_data    <= '0;
            out_src     <= '0;
            out_t_grant <= '0;
            rr_ptr      <= '0;
        end else if (load_en) begin
            out_valid   <= 1'b1;
            out_type    <= msgs[grant_idx].msg_type;
            out_data    <= msgs[grant_idx].data;
            out_src     <= grant_idx;
            out_t_grant <= cycle_cnt;
            rr_ptr      <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt [NUM_REQ];
    logic [STAT_W-1:0] stall_cnt;

    // Counters stick at all-ones until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (grant_cnt[i] != '1))
                    grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
            end
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_grants[g*STAT_W +: STAT_W] = grant_cnt[g];
    end
    assign stat_stall = stall_cnt;
`else
    assign stat_grants = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_l2t_arbiter.sv
// Directed self-checking bench for l2t_arbiter (NUM_REQ=4); stats checks follow ARB_STATS_EN.
module tb_l2t_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     cycle_cnt;
    logic [N-1:0]    req_valid;
    logic [N*8-1:0]  req_type;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [7:0]      out_type;
    logic [31:0]     out_data;
    logic [1:0]      out_src;
    logic [31:0]     out_t_grant;
    logic            out_ready;
    logic [N*16-1:0] stat_grants;
    logic [15:0]     stat_stall;

    int total = 0;
    int bad   = 0;

    l2t_arbiter #(.NUM_REQ(N), .STAT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cycle_cnt   (cycle_cnt),
        .req_valid   (req_valid),
        .req_type    (req_type),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_type    (out_type),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_t_grant (out_t_grant),
        .out_ready   (out_ready),
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle_cnt = cycle_cnt + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_lanes();
        for (int i = 0; i < N; i++) begin
            req_type[i*8 +: 8]   = 8'h10 + 8'(i);
            req_data[i*32 +: 32] = 32'h1000 + 32'(i);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        cycle_cnt = 0;
        load_lanes();
        tick();
        tick();
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        total++; if ({out_type, out_data, out_src, out_t_grant} !== 74'h0) begin bad++;
            $display("FAIL reset_payload got type=%h data=%h src=%0d t=%0d exp all 0", out_type, out_data, out_src, out_t_grant); end
        rst       = 1'b0;
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        cycle_cnt            = 100;
        req_valid            = 4'b0100;
        req_type[2*8 +: 8]   = 8'h41;
        req_data[2*32 +: 32] = 32'hDEADBEEF;
        out_ready            = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got %b exp 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        total++; if (out_valid !== 1'b1 || out_type !== 8'h41 || out_data !== 32'hDEADBEEF) begin bad++;
            $display("FAIL single_msg got v=%b type=%h data=%h exp v=1 type=41 data=deadbeef", out_valid, out_type, out_data); end
        total++; if (out_src !== 2'd2 || out_t_grant !== 32'd100) begin bad++;
            $display("FAIL single_tag got src=%0d t=%0d exp src=2 t=100", out_src, out_t_grant); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 32'hDEADBEEF) begin bad++;
            $display("FAIL single_drain got v=%b data=%h exp v=0 data=deadbeef", out_valid, out_data); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_t;
        logic [1:0]  exp_src;
        load_lanes();
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_src = 2'(k % 4);
            exp_t   = cycle_cnt;
            #1;
            total++; if (req_ready !== (4'b0001 << exp_src)) begin bad++;
                $display("FAIL rr_req_ready[%0d] got %b exp %b", k, req_ready, 4'b0001 << exp_src); end
            tick();
            total++; if (out_valid !== 1'b1 || out_src !== exp_src || out_type !== 8'h10 + 8'(exp_src) || out_t_grant !== exp_t) begin bad++;
                $display("FAIL rr_out[%0d] got v=%b src=%0d type=%h t=%0d exp v=1 src=%0d type=%h t=%0d",
                         k, out_valid, out_src, out_type, out_t_grant, exp_src, 8'h10 + 8'(exp_src), exp_t); end
        end
    endtask

    // Slot holds requester 1 from the round-robin run; the pointer now sits at 2.
    task automatic test_backpressure();
        logic [31:0] held_t;
        held_t    = out_t_grant;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_req_ready[%0d] got %b exp 0000", k, req_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 32'h1001 || out_t_grant !== held_t) begin bad++;
                $display("FAIL bp_hold[%0d] got v=%b src=%0d data=%h t=%0d exp v=1 src=1 data=1001 t=%0d",
                         k, out_valid, out_src, out_data, out_t_grant, held_t); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got %b exp 0100", req_ready); end
        tick();
        total++; if (out_src !== 2'd2 || out_valid !== 1'b1) begin bad++;
            $display("FAIL bp_release_src got src=%0d v=%b exp src=2 v=1", out_src, out_valid); end
    endtask

    task automatic test_drain_load();
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL dl_req_ready got %b exp 0001", req_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_type !== 8'h10) begin bad++;
            $display("FAIL dl_replace got v=%b src=%0d type=%h exp v=1 src=0 type=10", out_valid, out_src, out_type); end
        // Pointer is 1: requester 3 beats 0, then the pointer wraps to 0.
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_first got %b exp 1000", req_ready); end
        tick();
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_second got %b exp 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        total++; if (out_valid !== 1'b0 || out_src !== 2'd0) begin bad++;
            $display("FAIL dl_idle got v=%b src=%0d exp v=0 src=0", out_valid, out_src); end
    endtask

    task automatic test_reset_mid_stall();
        req_valid = 4'b0010;
        out_ready = 1'b0;
        tick();
        req_valid = 4'b0000;
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin bad++;
            $display("FAIL rms_setup got v=%b src=%0d exp v=1 src=1", out_valid, out_src); end
        do_reset();
        total++; if (out_valid !== 1'b0 || out_src !== 2'd0) begin bad++;
            $display("FAIL rms_discard got v=%b src=%0d exp v=0 src=0", out_valid, out_src); end
        out_ready = 1'b1;
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rms_ptr_zero got %b exp 0001", req_ready); end
        req_valid = 4'b1000;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rms_idx3 got %b exp 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        total++; if (out_src !== 2'd3 || out_valid !== 1'b1) begin bad++;
            $display("FAIL rms_idx3_out got src=%0d v=%b exp src=3 v=1", out_src, out_valid); end
        tick();
    endtask

    task automatic test_stats();
`ifdef ARB_STATS_EN
        do_reset();
        total++; if (stat_grants !== 64'h0 || stat_stall !== 16'h0) begin bad++;
            $display("FAIL stats_reset got grants=%h stall=%h exp 0", stat_grants, stat_stall); end
        out_ready = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) tick();
        req_valid = 4'b0000;
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        total++; if (stat_grants[16 +: 16] !== 16'd10 || stat_stall !== 16'd7) begin bad++;
            $display("FAIL stats_count got g1=%0d stall=%0d exp g1=10 stall=7", stat_grants[16 +: 16], stat_stall); end
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 65540; k++) tick();
        req_valid = 4'b0000;
        total++; if (stat_grants[15:0] !== 16'hFFFF || stat_grants[63:16] !== 48'h0) begin bad++;
            $display("FAIL stats_saturate got grants=%h exp 000000000000ffff", stat_grants); end
`else
        out_ready = 1'b0;
        req_valid = 4'b0100;
        tick();
        tick();
        req_valid = 4'b0000;
        total++; if (stat_grants !== 64'h0 || stat_stall !== 16'h0) begin bad++;
            $display("FAIL stats_tied got grants=%h stall=%h exp 0", stat_grants, stat_stall); end
        out_ready = 1'b1;
        tick();
`endif
    endtask

    initial begin
        req_valid = '0;
        req_type  = '0;
        req_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain_load();
        test_reset_mid_stall();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2t_arbiter.md
Name: l2t_arbiter

Overview:
- Shares the single Logic→TX pipeline stage between NUM_REQ decision engines (strategy, cancel/risk, heartbeat).
- Round-robin arbitration among valid requesters; the winning message is registered into one output slot that feeds the Logic→TX stage input.
- Output slot is tagged with source index and grant timestamp.
- Full throughput: one message per cycle when downstream is ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, $clog2(NUM_REQ) with minimum 1, width of source index.
- STAT_W, 16, width of each statistics counter (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cycle_cnt  in  32  free-running cycle counter
- req_valid  in  NUM_REQ  per-requester message valid
- req_type  in  NUM_REQ*8  packed message types; requester i occupies [8i+7:8i]
- req_data  in  NUM_REQ*32  packed message payloads
- req_ready  out  NUM_REQ  one-hot accept strobe
- out_valid  out  1  output slot holds a message
- out_type  out  8  granted message type
- out_data  out  32  granted payload
- out_src  out  SRC_W  index of granted requester
- out_t_grant  out  32  cycle_cnt value at grant
- out_ready  in  1  downstream (Logic→TX stage) ready
- stat_grants  out  NUM_REQ*STAT_W  per-requester grant counts
- stat_stall  out  STAT_W  count of stalled cycles

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - out_valid=0; out_type, out_data, out_src and out_t_grant=0.
  - rr_ptr=0; stats=0.
  - req_ready=0 while rst is high.
- load_en = (!out_valid || out_ready) && |req_valid. This is combinational; no dependency on the same-cycle req_ready.
- Grant selection:
  - Select the first set req_valid[i] searching i = rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - grant is one-hot or zero.
  - req_ready = grant & {NUM_REQ{load_en}}.
- On load_en at posedge:
  - The output slot takes the winner's type/data; out_src=i; out_t_grant=cycle_cnt; out_valid=1.
  - rr_ptr=(i+1) mod NUM_REQ.
- Otherwise, if out_valid && out_ready: out_valid=0. Payload registers hold their last values.
- out_valid && !out_ready: slot and rr_ptr are frozen and req_ready=0 (backpressure to all requesters).
- Drain and load in the same cycle: the slot is replaced with no bubble. Back-to-back requests achieve 1 msg/cycle.
- Latency: request accepted at edge N appears on out_* at edge N (registered). It is visible to downstream in cycle N+1.
- Requester contract: req_valid/payload held stable until req_ready. The block does not register unaccepted requests.
- rr_ptr only advances on a grant. Idle cycles leave it unchanged.
- Fairness bound: a continuously-valid requester is granted within NUM_REQ grants.
- rst mid-operation: any message in the slot is discarded, not delivered. Requesters re-present after reset.
- Invalid requester index ≥ NUM_REQ cannot occur; rr_ptr wraps at NUM_REQ, not 2^SRC_W.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - stat_grants[i] increments on each req_ready[i].
  - stat_stall increments each cycle with out_valid && !out_ready.
  - All counters saturate at all-ones and clear only on rst.
- Undefined: stat_grants and stat_stall are tied to 0 and no counter flops are inferred. The port list is identical either way.

Decomposition:
- Package l2t_arb_pkg: TYPE_W=8, DATA_W=32, TS_W=32; l2t_msg_t struct {type, data}.
- Sub-module rr_grant (parameter N): inputs req vector and rr_ptr; output one-hot grant and binary index; purely combinational rotate/priority-encode/unrotate.
- The rr_ptr flop stays in l2t_arbiter.

Test Plan:
- Single requester: after reset, req_valid=4'b0100, type=0x41, data=0xDEADBEEF, out_ready=1, cycle_cnt=100 → req_ready=4'b0100 that cycle. Next cycle: out_valid=1, out_type=0x41, out_data=0xDEADBEEF, out_src=2, out_t_grant=100.
- Round-robin: all four valid continuously with out_ready=1 → grant order 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Backpressure: slot full, out_ready=0 for 5 cycles, req_valid=4'b1111 → req_ready=0 and out_* stable for 5 cycles. On release, the next grant follows rr_ptr.
- Drain+load same cycle: out_valid=1, out_ready=1, req_valid=4'b0001 → slot replaced, out_valid stays 1, no idle cycle.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle → out_valid=0, rr_ptr=0. The next request from index 3 wins only if 0..2 are idle.
- With ARB_STATS_EN: 10 grants to requester 1 and 7 stall cycles → stat_grants[1]=10, stat_stall=7. Force 65540 grants → stat_grants saturates at 0xFFFF.
